// File: rtl/alu_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_req_arbiter_if
//   Bundles every non-clock signal of the shared-ALU arbiter:
//     req0_* / req1_*   valid/ready request channels (op, operands a/b)
//     alu_a/b/s, alu_out  registered operands + select to the ALU, ALU result
//     rsp_*              valid/ready tagged response channel
//     busy               arbiter has an op in flight or a response pending
//   Modports:
//     slave  - the arbiter itself
//     master - the surroundings (requesters, ALU, response consumer)
// -----------------------------------------------------------------------------
interface alu_req_arbiter_if #(
  parameter int unsigned WIDTH = 40
);
  logic             req0_valid;
  logic             req0_ready;
  logic [4:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [4:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [4:0]       alu_s;
  logic [WIDTH-1:0] alu_out;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;
  logic             rsp_err;

  logic             busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_out, rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_s,
    output rsp_valid, rsp_data, rsp_id, rsp_err, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_out, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_s,
    input  rsp_valid, rsp_data, rsp_id, rsp_err, busy
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// alu_req_arbiter
//   Shares one registered WIDTH-bit ALU between two requesters. One op is in
//   flight at a time: IDLE -> EXEC -> RESP -> IDLE, or IDLE -> RESP directly
//   for rejected ops (illegal opcode, divide by zero), which never reach the
//   ALU. Results come back tagged with the requester id on a valid/ready
//   response channel.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (drops any in-flight op)
//     bus    alu_req_arbiter_if.slave (requests, ALU side, response, busy)
//   Configuration macro:
//     ALU_ARB_FIXED_PRI_EN  defined: requester 0 always wins contention.
//                           undefined: round-robin, requester 0 wins first.
// -----------------------------------------------------------------------------
module alu_req_arbiter #(
  parameter int unsigned WIDTH    = 40,
  parameter int unsigned ALU_LAT  = 1,
  parameter logic [4:0]  NOP_CODE = 5'b00000
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_req_arbiter_if.slave bus
);

  localparam logic [4:0] OP_ADD = 5'b00101;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_MUL = 5'b01000;
  localparam logic [4:0] OP_DIV = 5'b01011;

  localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_e;

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [WIDTH-1:0] alu_a_q,    alu_a_d;
  logic [WIDTH-1:0] alu_b_q,    alu_b_d;
  logic [4:0]       alu_s_q,    alu_s_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_id_q,   rsp_id_d;
  logic             rsp_err_q,  rsp_err_d;
  logic             busy_q,     busy_d;
`ifndef ALU_ARB_FIXED_PRI_EN
  logic             rr_q,       rr_d;   // id of the last requester granted
`endif

  logic             grant_id;
  logic             accept;
  logic [4:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             op_legal;

  // ---------------------------------------------------------------------------
  // Grant selection. With a single valid requester it always wins; under
  // contention the fixed-priority build favours requester 0, the round-robin
  // build favours whoever was not granted last.
  // ---------------------------------------------------------------------------
`ifdef ALU_ARB_FIXED_PRI_EN
  assign grant_id = !bus.req0_valid;
`else
  assign grant_id = (bus.req0_valid && bus.req1_valid) ? !rr_q : bus.req1_valid;
`endif

  assign accept         = (state_q == S_IDLE) && (bus.req0_valid || bus.req1_valid);
  assign bus.req0_ready = accept && !grant_id;
  assign bus.req1_ready = accept &&  grant_id;

  assign sel_op = grant_id ? bus.req1_op : bus.req0_op;
  assign sel_a  = grant_id ? bus.req1_a  : bus.req0_a;
  assign sel_b  = grant_id ? bus.req1_b  : bus.req0_b;

  assign op_legal = (sel_op == OP_ADD) || (sel_op == OP_SUB) ||
                    (sel_op == OP_MUL) || (sel_op == OP_DIV);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_s_d    = alu_s_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rsp_err_d  = rsp_err_q;
`ifndef ALU_ARB_FIXED_PRI_EN
    rr_d       = rr_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          rsp_id_d = grant_id;
`ifndef ALU_ARB_FIXED_PRI_EN
          rr_d     = grant_id;
`endif
          if (!op_legal) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = S_RESP;
          end else if ((sel_op == OP_DIV) && (sel_b == '0)) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '1;
            state_d    = S_RESP;
          end else begin
            alu_a_d = sel_a;
            alu_b_d = sel_b;
            alu_s_d = sel_op;
            cnt_d   = CNT_W'(ALU_LAT);
            state_d = S_EXEC;
          end
        end
      end

      // Operands and select stay put while counting; on the edge where the
      // count has reached zero the ALU output has settled for ALU_LAT edges.
      S_EXEC: begin
        if (cnt_q == '0) begin
          rsp_data_d = bus.alu_out;
          rsp_err_d  = 1'b0;
          alu_s_d    = NOP_CODE;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= NOP_CODE;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifndef ALU_ARB_FIXED_PRI_EN
      rr_q        <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_s_q     <= alu_s_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
`ifndef ALU_ARB_FIXED_PRI_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_s     = alu_s_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;

endmodule
